seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed driver for a bank of common-anode seven-segment digits. It latches a packed word of hex nibbles, decimal-point bits and blank bits. It then scans the digits one at a time with a programmable refresh period, drives active-low segment and anode lines, and inserts a dead-time guard between digits to suppress ghosting. It generalises the single-digit, externally-selected decoder into a self-scanning, N-digit display controller that sits between datapath registers and the board display pins.

## Interface
- NUM_DIGITS, 8, digits scanned; legal range 1..16
- REFRESH_DIV, 100000, clock cycles per digit slot; ≥ 2
- GUARD, 16, dead cycles at start of each slot with all anodes off; 0 ≤ GUARD < REFRESH_DIV
- clk  in  1  single system clock, rising edge
- rst_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- load  in  1  capture digit_data/dp_in/blank_in into shadow registers at this edge
- digit_data  in  4*NUM_DIGITS  nibble k = bits [4k+3:4k] = value for digit k
- dp_in  in  NUM_DIGITS  bit k = 1 lights decimal point of digit k
- blank_in  in  NUM_DIGITS  bit k = 1 keeps digit k dark for its whole slot
- seg  out  7  active-low segments, seg[6]=A … seg[0]=G
- dp_n  out  1  active-low decimal point
- an  out  NUM_DIGITS  active-low anode enables, at most one low
- frame_done  out  1  one-cycle pulse when the last digit's slot ends

## Operation
- State: slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..NUM_DIGITS-1), shadow data/dp/blank registers. Widths are clog2 of each range, minimum 1 bit.
- Every cycle cnt increments. At cnt==REFRESH_DIV-1, cnt wraps to 0 and idx advances. idx wraps NUM_DIGITS-1 → 0.
- frame_done registers high for exactly one cycle, on the cycle after cnt==REFRESH_DIV-1 with idx==NUM_DIGITS-1.
- Shadow registers load on any edge with load=1. Without load they hold. Updates mid-slot take effect on the next output update; no wait for a frame boundary.
- Output register (updated every edge from the current cnt/idx/shadow):
  - If cnt < GUARD or blank[idx]: an is all 1, seg=7'b1111111, dp_n=1.
  - Otherwise: an = ~(1<<idx), seg = active-low hex glyph of nibble idx, dp_n = ~dp[idx].
- Glyphs (ABCDEFG, 1=lit, before inversion):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- NUM_DIGITS=1: idx stays 0. an[0] is low for every non-guard, non-blank cycle.

## Timing
- Reset (rst_n=0 at an edge): cnt=0, idx=0, shadow data/dp=0, shadow blank=all 1. Outputs an=all 1, seg=7'h7F, dp_n=1, frame_done=0. Reset mid-slot or mid-frame aborts immediately; there is no partial-frame completion.
- Output latency: 1 cycle after the state that produced it. Taking cycle 0 as the first edge with rst_n=1, digit k is driven from edge k·REFRESH_DIV+GUARD+1 through edge (k+1)·REFRESH_DIV inclusive.
- Frame period = NUM_DIGITS·REFRESH_DIV cycles. frame_done first asserts at edge NUM_DIGITS·REFRESH_DIV.
- Load-to-display latency: load at edge t changes seg at edge t+1 if that edge is in the active portion of the slot.
- load concurrent with reset: reset wins.
- Invariant: an never has two bits low. It changes between two different low bits only via an all-1 cycle when GUARD ≥ 1.

## Test plan
Unless stated otherwise, benches use NUM_DIGITS=8, REFRESH_DIV=4, GUARD=1.
- Reset: hold rst_n=0 for 3 cycles with load=1 and arbitrary data → an=8'hFF, seg=7'h7F, dp_n=1, frame_done=0 throughout. After release with no load, all digits stay blank.
- Full scan: load digit_data=32'h76543210, dp_in=8'h01, blank_in=0 → each 4-cycle slot shows 1 dark cycle, then 3 cycles of an=~(1<<k) with glyph k. Digit 0 has seg=7'b0000001 and dp_n=0. frame_done pulses every 32 cycles.
- Blanking and glyphs: load digit_data=32'hFEDCBA98, blank_in=8'hAA → odd digits never drive an low. Digit 2 shows seg=~7'b1110111 (A); digit 6 shows ~7'b1001111 (E).
- Mid-slot load: during digit 3's active cycles, load nibble 3 from 0 to 8 → seg becomes 7'b0000000 the next cycle while an stays 8'hF7.
- Reset mid-frame: assert rst_n=0 for 1 cycle during digit 5 → the next edge gives an=8'hFF and shadow cleared. The scan restarts at digit 0 with frame_done 32 cycles later.
- Corners: NUM_DIGITS=1, GUARD=0, REFRESH_DIV=2 → an=1'b0 on every cycle after the first post-reset edge, frame_done pulses every 2 cycles. With GUARD=REFRESH_DIV-1, each digit is lit exactly 1 cycle per slot.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Self-scanning N-digit common-anode seven-segment driver: shadows hex nibbles,
// decimal points and blank bits, then time-multiplexes them with a per-slot dead-time guard.
module seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS  = 8,
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned GUARD       = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   digit_data,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     blank_in,
   output logic [6:0]                seg,
   output logic                      dp_n,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      frame_done
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]        r_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic [4*NUM_DIGITS-1:0] r_data;
   logic [NUM_DIGITS-1:0]   r_dp;
   logic [NUM_DIGITS-1:0]   r_blank;
   logic [6:0]              r_seg;
   logic                    r_dp_n;
   logic [NUM_DIGITS-1:0]   r_an;
   logic                    r_frame_done;

   logic                    w_guard;
   logic                    w_cnt_last;
   logic                    w_idx_last;
   logic [3:0]              w_nib;
   logic                    w_dp;
   logic                    w_blank;
   logic [NUM_DIGITS-1:0]   w_an_sel;
   logic [6:0]              w_glyph;

   assign w_cnt_last = (r_cnt == CNT_LAST);
   assign w_idx_last = (r_idx == IDX_LAST);

   // Dead-time window at the start of each slot; absent entirely when GUARD is zero.
   generate
      if (GUARD == 0) begin : g_no_guard
         assign w_guard = 1'b0;
      end else begin : g_guard
         localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);
         assign w_guard = (r_cnt < GUARD_C);
      end
   endgenerate

   always_comb begin
      w_nib    = 4'h0;
      w_dp     = 1'b0;
      w_blank  = 1'b1;
      w_an_sel = '1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_nib       = r_data[4*k +: 4];
            w_dp        = r_dp[k];
            w_blank     = r_blank[k];
            w_an_sel[k] = 1'b0;
         end
      end
   end

   // Hex glyphs in ABCDEFG order, 1 = segment lit.
   always_comb begin
      w_glyph = 7'b0000000;
      case (w_nib)
         4'h0: w_glyph = 7'b1111110;
         4'h1: w_glyph = 7'b0110000;
         4'h2: w_glyph = 7'b1101101;
         4'h3: w_glyph = 7'b1111001;
         4'h4: w_glyph = 7'b0110011;
         4'h5: w_glyph = 7'b1011011;
         4'h6: w_glyph = 7'b1011111;
         4'h7: w_glyph = 7'b1110000;
         4'h8: w_glyph = 7'b1111111;
         4'h9: w_glyph = 7'b1111011;
         4'hA: w_glyph = 7'b1110111;
         4'hB: w_glyph = 7'b0011111;
         4'hC: w_glyph = 7'b1001110;
         4'hD: w_glyph = 7'b0111101;
         4'hE: w_glyph = 7'b1001111;
         4'hF: w_glyph = 7'b1000111;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_idx        <= '0;
         r_data       <= '0;
         r_dp         <= '0;
         r_blank      <= '1;
         r_an         <= '1;
         r_seg        <= 7'h7F;
         r_dp_n       <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         if (w_cnt_last) begin
            r_cnt <= '0;
            r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         r_frame_done <= w_cnt_last && w_idx_last;

         if (load) begin
            r_data  <= digit_data;
            r_dp    <= dp_in;
            r_blank <= blank_in;
         end

         // Outputs reflect the state before this edge, giving one cycle of latency.
         if (w_guard || w_blank) begin
            r_an   <= '1;
            r_seg  <= 7'h7F;
            r_dp_n <= 1'b1;
         end else begin
            r_an   <= w_an_sel;
            r_seg  <= ~w_glyph;
            r_dp_n <= ~w_dp;
         end
      end
   end

   assign seg        = r_seg;
   assign dp_n       = r_dp_n;
   assign an         = r_an;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: three instances (8 digits/guard 1, single digit/no guard,
// 8 digits/guard=REFRESH_DIV-1) share directed stimulus; a monitor checks every edge.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [31:0] digit_data = '0;
   logic [7:0]  dp_in = '0;
   logic [7:0]  blank_in = '0;

   logic [6:0] seg_a, seg_b, seg_c;
   logic       dpn_a, dpn_b, dpn_c;
   logic [7:0] an_a, an_c;
   logic [0:0] an_b;
   logic       fd_a, fd_b, fd_c;

   int checks = 0;
   int failures = 0;
   int fd_count_a = 0;
   int fd_count_b = 0;

   logic [16:0] q0[$];
   logic [16:0] q1[$];
   logic [16:0] q2[$];

   // Reference model state: per-instance counters, shared shadow registers.
   int          m_cnt[3];
   int          m_idx[3];
   int          nd[3] = '{8, 1, 8};
   int          rd[3] = '{4, 2, 4};
   int          gd[3] = '{1, 0, 3};
   logic [31:0] m_data = '0;
   logic [7:0]  m_dp = '0;
   logic [7:0]  m_blank = '1;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(4), .GUARD(1)) u_a (
      .clk(clk), .rst_n(rst_n), .load(load), .digit_data(digit_data), .dp_in(dp_in),
      .blank_in(blank_in), .seg(seg_a), .dp_n(dpn_a), .an(an_a), .frame_done(fd_a));

   seg_scan_ctrl #(.NUM_DIGITS(1), .REFRESH_DIV(2), .GUARD(0)) u_b (
      .clk(clk), .rst_n(rst_n), .load(load), .digit_data(digit_data[3:0]), .dp_in(dp_in[0:0]),
      .blank_in(blank_in[0:0]), .seg(seg_b), .dp_n(dpn_b), .an(an_b), .frame_done(fd_b));

   seg_scan_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(4), .GUARD(3)) u_c (
      .clk(clk), .rst_n(rst_n), .load(load), .digit_data(digit_data), .dp_in(dp_in),
      .blank_in(blank_in), .seg(seg_c), .dp_n(dpn_c), .an(an_c), .frame_done(fd_c));

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: glyph = 7'b1111110;  4'h1: glyph = 7'b0110000;
         4'h2: glyph = 7'b1101101;  4'h3: glyph = 7'b1111001;
         4'h4: glyph = 7'b0110011;  4'h5: glyph = 7'b1011011;
         4'h6: glyph = 7'b1011111;  4'h7: glyph = 7'b1110000;
         4'h8: glyph = 7'b1111111;  4'h9: glyph = 7'b1111011;
         4'hA: glyph = 7'b1110111;  4'hB: glyph = 7'b0011111;
         4'hC: glyph = 7'b1001110;  4'hD: glyph = 7'b0111101;
         4'hE: glyph = 7'b1001111;  default: glyph = 7'b1000111;
      endcase
   endfunction

   // Expected {an, seg, dp_n, frame_done} at the coming edge; single-digit an padded with 1s.
   function automatic logic [16:0] model_out(input int d);
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dpn;
      logic       e_fd;
      int         k;
      k    = m_idx[d];
      e_fd = (m_cnt[d] == rd[d] - 1) && (m_idx[d] == nd[d] - 1);
      if (m_cnt[d] < gd[d] || m_blank[k]) begin
         e_an  = 8'hFF;
         e_seg = 7'h7F;
         e_dpn = 1'b1;
      end else begin
         e_an  = ~(8'h01 << k);
         e_seg = ~glyph(m_data[4*k +: 4]);
         e_dpn = ~m_dp[k];
      end
      return {e_an, e_seg, e_dpn, e_fd};
   endfunction

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got an=%h seg=%b dp_n=%b fd=%b expected an=%h seg=%b dp_n=%b fd=%b",
                  name, $time, act[16:9], act[8:2], act[1], act[0],
                  exp[16:9], exp[8:2], exp[1], exp[0]);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Drive one edge worth of inputs, queue expectations, advance the model past that edge.
   task automatic step(input logic r, input logic ld, input logic [31:0] d,
                       input logic [7:0] p, input logic [7:0] b);
      logic [16:0] e;
      @(negedge clk);
      rst_n = r; load = ld; digit_data = d; dp_in = p; blank_in = b;
      for (int i = 0; i < 3; i++) begin
         e = r ? model_out(i) : {8'hFF, 7'h7F, 1'b1, 1'b0};
         if (i == 0) q0.push_back(e);
         else if (i == 1) q1.push_back(e);
         else q2.push_back(e);
         if (!r) begin
            m_cnt[i] = 0;
            m_idx[i] = 0;
         end else if (m_cnt[i] == rd[i] - 1) begin
            m_cnt[i] = 0;
            m_idx[i] = (m_idx[i] == nd[i] - 1) ? 0 : m_idx[i] + 1;
         end else begin
            m_cnt[i] = m_cnt[i] + 1;
         end
      end
      if (!r) begin
         m_data = '0; m_dp = '0; m_blank = '1;
      end else if (ld) begin
         m_data = d; m_dp = p; m_blank = b;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
   endtask

   // Monitor: compares every edge that has a queued expectation.
   always @(posedge clk) begin
      #1;
      if (q0.size() > 0) begin
         check("dut_a_outputs", {an_a, seg_a, dpn_a, fd_a}, q0.pop_front());
         check_int("dut_a_an_onehot", ($countones(~an_a) > 1) ? 1 : 0, 0);
         if (fd_a) fd_count_a++;
      end
      if (q1.size() > 0) begin
         check("dut_b_outputs", {7'h7F, an_b, seg_b, dpn_b, fd_b}, q1.pop_front());
         if (fd_b) fd_count_b++;
      end
      if (q2.size() > 0) begin
         check("dut_c_outputs", {an_c, seg_c, dpn_c, fd_c}, q2.pop_front());
         check_int("dut_c_an_onehot", ($countones(~an_c) > 1) ? 1 : 0, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int snap_a;
      int snap_b;
      int guard_n;
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0;
         m_idx[i] = 0;
      end

      // Reset held with load active: reset wins, then nothing loaded so all dark.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hDEADBEEF, 8'hFF, 8'h00);
      idle(40);

      // Full scan with digit 0 decimal point; count frame pulses over 64 edges.
      step(1'b1, 1'b1, 32'h76543210, 8'h01, 8'h00);
      idle(8);
      snap_a = fd_count_a;
      snap_b = fd_count_b;
      idle(64);
      @(posedge clk);
      #2;
      check_int("frame_done_count_a", fd_count_a - snap_a, 2);
      check_int("frame_done_count_b", fd_count_b - snap_b, 32);

      // Blanking of odd digits with the upper glyph range.
      step(1'b1, 1'b1, 32'hFEDCBA98, 8'h44, 8'hAA);
      idle(40);

      // Mid-slot load: nibble 3 goes 0 -> 8 while digit 3 is lit.
      step(1'b1, 1'b1, 32'h76540210, 8'h00, 8'h00);
      guard_n = 0;
      while (!(m_cnt[0] == 2 && m_idx[0] == 3) && guard_n < 64) begin
         idle(1);
         guard_n++;
      end
      check_int("midslot_reach", (guard_n < 64) ? 1 : 0, 1);
      step(1'b1, 1'b1, 32'h76548210, 8'h00, 8'h00);
      idle(1);
      @(posedge clk);
      #2;
      check("midslot_hand", {an_a, seg_a, dpn_a, fd_a}, {8'hF7, 7'b0000000, 1'b1, 1'b0});
      idle(20);

      // Reset mid-frame during digit 5, with a load that must be ignored.
      guard_n = 0;
      while (m_idx[0] != 5 && guard_n < 64) begin
         idle(1);
         guard_n++;
      end
      step(1'b0, 1'b1, 32'h12345678, 8'hFF, 8'h00);
      @(posedge clk);
      #2;
      check("reset_midframe_hand", {an_a, seg_a, dpn_a, fd_a}, {8'hFF, 7'h7F, 1'b1, 1'b0});
      idle(12);
      step(1'b1, 1'b1, 32'h89ABCDEF, 8'hF0, 8'h00);
      idle(50);

      @(posedge clk);
      #3;
      check_int("queues_drained", q0.size() + q1.size() + q2.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
